// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the bit-serial unsigned comparator.
// Holds the default operand width, the comparator state enum and its flag mapping.
package seq_cmp_pkg;

    parameter int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        EQ,
        LT,
        GT
    } cmp_state_t;

    // Flags are packed as {L, E, G}.
    function automatic logic [2:0] state_to_flags(cmp_state_t s);
        logic [2:0] flags;
        flags = 3'b010;
        unique case (s)
            EQ:      flags = 3'b010;
            LT:      flags = 3'b100;
            GT:      flags = 3'b001;
            default: flags = 3'b010;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/linear_shift_register.sv
// Rotating operand serialiser: loads in parallel on reset, then rotates right,
// presenting one bit per clock, LSB first, wrapping forever.
module linear_shift_register #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inp,
    output logic             out
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= inp;
        end else begin
            sr_q <= {sr_q[0], sr_q[WIDTH-1:1]};
        end
    end

    assign out = sr_q[0];

endmodule

// File: rtl/sequential_unsigned_comparator.sv
// Serial unsigned comparator FSM consuming one bit pair per clock for WIDTH clocks.
// op=0: last differing bit decides; op=1: first differing bit locks the result.
module sequential_unsigned_comparator
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic op,
    input  logic a,
    input  logic b,
    output logic L,
    output logic E,
    output logic G,
    output logic done
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    cmp_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            op_q, op_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        op_d    = op_q;
        if (op != op_q) begin
            // Mode change restarts the compare without consuming the current bit.
            state_d = EQ;
            cnt_d   = '0;
            done_d  = 1'b0;
            op_d    = op;
        end else if (!done_q) begin
            if (a != b && (!op_q || state_q == EQ)) begin
                state_d = a ? GT : LT;
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EQ;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            op_q    <= op;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            op_q    <= op_d;
        end
    end

    assign {L, E, G} = state_to_flags(state_q);
    assign done      = done_q;

endmodule

// File: rtl/seq_unsigned_compare.sv
// Bit-serial unsigned magnitude comparator: two rotating operand serialisers
// feeding the serial compare FSM.
module seq_unsigned_compare
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    output logic             a,
    output logic             b,
    output logic             L,
    output logic             E,
    output logic             G,
    output logic             done
);

    linear_shift_register #(
        .WIDTH(WIDTH)
    ) u_sra (
        .clk  (clk),
        .reset(reset),
        .inp  (inp_a),
        .out  (a)
    );

    linear_shift_register #(
        .WIDTH(WIDTH)
    ) u_srb (
        .clk  (clk),
        .reset(reset),
        .inp  (inp_b),
        .out  (b)
    );

    sequential_unsigned_comparator #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .clk (clk),
        .rst (reset),
        .op  (op),
        .a   (a),
        .b   (b),
        .L   (L),
        .E   (E),
        .G   (G),
        .done(done)
    );

endmodule

// File: tb/tb_seq_unsigned_compare.sv
// Self-checking bench: an operand-level model of the serial compare is checked
// every cycle, plus hand-computed expectations at fixed edges.
module tb_seq_unsigned_compare;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op = 1'b0;
    logic [W-1:0] inp_a = '0;
    logic [W-1:0] inp_b = '0;
    logic         a, b, L, E, G, done;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Model: loaded operands, currently presented bit index, compare start bit,
    // number of bits consumed, and the active mode.
    logic [W-1:0] m_a, m_b;
    int           m_pos, m_st, m_n;
    logic         m_op;
    bit           m_valid = 1'b0;

    seq_unsigned_compare #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .op   (op),
        .inp_a(inp_a),
        .inp_b(inp_b),
        .a    (a),
        .b    (b),
        .L    (L),
        .E    (E),
        .G    (G),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) edge_no <= 0;
        else       edge_no <= edge_no + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_a = inp_a;
            m_b = inp_b;
            m_pos = 0;
            m_st = 0;
            m_n = 0;
            m_op = op;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_pos = (m_pos + 1) % W;
            if (op != m_op) begin
                m_op = op;
                m_st = m_pos;
                m_n = 0;
            end else if (m_n < W) begin
                m_n = m_n + 1;
            end
        end
    end

    // Result over the consumed bits in stream order: 0 equal, 1 A<B, 2 A>B.
    function automatic logic [2:0] exp_flags();
        int res = 0;
        int idx;
        for (int j = 0; j < m_n; j++) begin
            idx = (m_st + j) % W;
            if (m_a[idx] != m_b[idx] && (!m_op || res == 0)) res = m_a[idx] ? 2 : 1;
        end
        case (res)
            1:       return 3'b100;
            2:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp,
                     edge_no, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model flags", 32'({L, E, G}), 32'(exp_flags()));
            check("model done", 32'(done), 32'(m_n == W));
            check("model serial", 32'({a, b}), 32'({m_a[m_pos], m_b[m_pos]}));
        end
    end

    // Called at a negedge; holds reset across one rising edge.
    task automatic start(logic [W-1:0] va, logic [W-1:0] vb, logic vop);
        #1;
        reset = 1'b1;
        inp_a = va;
        inp_b = vb;
        op = vop;
        @(negedge clk);
        check("reset flags", 32'({L, E, G}), 32'(3'b010));
        check("reset done", 32'(done), 32'(0));
        check("reset serial", 32'({a, b}), 32'({va[0], vb[0]}));
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_at(int e, logic [2:0] leg, logic dn, string tag);
        while (edge_no < e) @(negedge clk);
        check({tag, " flags"}, 32'({L, E, G}), 32'(leg));
        check({tag, " done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);

        // FFFFFFFF vs 123, LSB-first, then op raised after done.
        start(32'hFFFF_FFFF, 32'd123, 1'b0);
        expect_at(1, 3'b010, 1'b0, "s1 e1");
        expect_at(2, 3'b010, 1'b0, "s1 e2");
        expect_at(3, 3'b001, 1'b0, "s1 e3");
        expect_at(31, 3'b001, 1'b0, "s1 e31");
        expect_at(32, 3'b001, 1'b1, "s1 e32");
        #1 op = 1'b1;
        expect_at(33, 3'b010, 1'b0, "s4 e33");
        expect_at(34, 3'b010, 1'b0, "s4 e34");
        expect_at(35, 3'b001, 1'b0, "s4 e35");
        expect_at(64, 3'b001, 1'b0, "s4 e64");
        expect_at(65, 3'b001, 1'b1, "s4 e65");

        // 5 vs 6: op=0 last difference wins, done holds afterwards.
        start(32'd5, 32'd6, 1'b0);
        expect_at(1, 3'b001, 1'b0, "s2 e1");
        expect_at(2, 3'b100, 1'b0, "s2 e2");
        expect_at(32, 3'b100, 1'b1, "s2 e32");
        expect_at(40, 3'b100, 1'b1, "s2 e40");

        // 5 vs 6: op=1 first difference locks; op changes while in reset.
        start(32'd5, 32'd6, 1'b1);
        expect_at(1, 3'b001, 1'b0, "s3 e1");
        expect_at(2, 3'b001, 1'b0, "s3 e2");
        expect_at(32, 3'b001, 1'b1, "s3 e32");

        // Equal operands under both modes.
        start(32'h8000_0001, 32'h8000_0001, 1'b0);
        expect_at(16, 3'b010, 1'b0, "s5a e16");
        expect_at(32, 3'b010, 1'b1, "s5a e32");
        start(32'h8000_0001, 32'h8000_0001, 1'b1);
        expect_at(31, 3'b010, 1'b0, "s5b e31");
        expect_at(32, 3'b010, 1'b1, "s5b e32");

        // Mid-word differences: bit 15 favours A, bit 16 favours B.
        start(32'h0000_8000, 32'h0001_0000, 1'b0);
        expect_at(16, 3'b001, 1'b0, "s7 e16");
        expect_at(17, 3'b100, 1'b0, "s7 e17");
        expect_at(32, 3'b100, 1'b1, "s7 e32");

        // Reset asserted at edge 10 with new operands 0 vs 1.
        start(32'hFFFF_FFFF, 32'd123, 1'b0);
        expect_at(9, 3'b001, 1'b0, "s6 e9");
        start(32'd0, 32'd1, 1'b0);
        expect_at(1, 3'b100, 1'b0, "s6 r1");
        expect_at(31, 3'b100, 1'b0, "s6 r31");
        expect_at(32, 3'b100, 1'b1, "s6 r32");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_unsigned_compare.md
# seq_unsigned_compare

Bit-serial unsigned magnitude comparator with its own operand serialisers. Two parallel WIDTH-bit words are loaded into rotating shift registers (`linear_shift_register`) and streamed LSB-first, one bit per clock, into a comparator FSM (`sequential_unsigned_comparator`). The FSM maintains one-hot less/equal/greater flags. It is the serial-compare datapath used wherever word comparison is traded for area.

## Interface
- `WIDTH`, default 32: operand width and compare length in bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `op`, input, 1: compare mode. 0 = last differing bit decides; 1 = first differing bit decides and locks.
- `inp_a`, input, WIDTH: operand A; loaded while `reset`=1.
- `inp_b`, input, WIDTH: operand B; loaded while `reset`=1.
- `a`, output, 1: current serial bit of A (`sra[0]`).
- `b`, output, 1: current serial bit of B (`srb[0]`).
- `L`, output, 1: A<B so far.
- `E`, output, 1: A==B so far.
- `G`, output, 1: A>B so far.
- `done`, output, 1: WIDTH bits compared; flags frozen.

## Operation
- Shift registers: on reset, `sr <= inp`. Otherwise rotate right, `sr <= {sr[0], sr[WIDTH-1:1]}`. Serial output is `sr[0]`, combinational from the register. The k-th cycle after reset presents bit k mod WIDTH, so the stream wraps forever.
- Comparator state: one of EQ, LT, GT, encoded one-hot on {L,E,G}. Exactly one flag is high at all times.
- Comparator registers: 6-bit (clog2(WIDTH)+1) bit counter `cnt`, `done`, and `op_q` (registered `op`).
- `op`=0 (LSB-first magnitude): each compare cycle with a≠b sets GT if a=1, b=0, or LT if a=0, b=1. If a==b, the state holds. After WIDTH bits the state reflects the most significant differing bit.
- `op`=1 (first-difference lock): only in EQ does a≠b move the state to GT or LT. Once in GT or LT the state holds until restart.
- Compare cycle: any clock edge with reset=0, done=0, and op==op_q. It increments `cnt`. When `cnt` reaches WIDTH-1, `done` is set and the state is frozen.
- Restart on op change: at an edge where op≠op_q, set state to EQ, cnt=0, done=0, op_q=op. No bit is consumed on that edge.
  - The shift registers are not affected and keep rotating.
  - The next WIDTH bits, i.e. a rotation of the operands starting at the current bit index, are compared.
- `inp_a` and `inp_b` are ignored when `reset`=0.

## Timing
- Reset values: L=0, E=1, G=0, done=0, cnt=0, op_q=op. Shift registers hold `inp`, so `a`=inp_a[0] and `b`=inp_b[0].
- Latency: flags are registered. After edge n (n ≥ 1) following reset release, they reflect bits 0..n-1.
- Final result is valid and `done`=1 after edge WIDTH, and holds until reset or an op change.
- Reset mid-compare: aborts on the same edge, reloads operands, and returns to the reset values.
- Reset and op change on the same edge: reset wins and op_q takes the new op.
- Equal operands: E stays 1 throughout and `done` rises at edge WIDTH.

## Structure
- Package `seq_cmp_pkg`: WIDTH default, the `cmp_state_t` enum {EQ, LT, GT}, and a helper mapping the state to {L,E,G}.
- Sub-modules: `linear_shift_register` (parameter WIDTH; ports clk, reset, inp, out), instantiated twice, and `sequential_unsigned_comparator` (ports clk, rst, op, a, b, L, E, G, done).
- The top only wires the three sub-modules together.

## Test plan
- inp_a=32'hFFFFFFFF, inp_b=123, op=0, reset for 1 cycle:
  - E=1 after edges 1–2, since bits 0–1 are equal.
  - G=1 from edge 3 (bit 2: a=1, b=0) onward.
  - done=1 at edge 32 with G=1.
- inp_a=5, inp_b=6, op=0: G after edge 1, L after edge 2, L final with done at edge 32.
- inp_a=5, inp_b=6, op=1: G after edge 1, locked; G final with done at edge 32.
- Same operands as the first scenario, op=0, with op raised to 1 at edge 33:
  - Restart to E, done=0 on that edge.
  - G locks at the first subsequent a≠b bit; done is reasserted 32 edges later.
- inp_a=inp_b=32'h80000001, either op: E=1 every cycle, done at edge 32.
- Assert reset at edge 10 with new operands inp_a=0, inp_b=1:
  - Flags return to E, and a=0, b=1 on the next cycle.
  - L from the following edge; done 32 edges after release.
